// File: rtl/sig_mon_pkg.sv
// Shared types and the MISR step function for the result signature monitor.
// misr_step is generic up to 64 bits so RTL and bench reference can both use it.
package sig_mon_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } sig_state_e;

   localparam int unsigned SIG_MAX_WIDTH = 64;

   // One MISR step in 'width' bits: shift left, fold in POLY when the MSB
   // falls off, xor in the sample; nothing carries above bit width-1.
   function automatic logic [SIG_MAX_WIDTH-1:0] misr_step(
      input logic [SIG_MAX_WIDTH-1:0] s,
      input logic [SIG_MAX_WIDTH-1:0] d,
      input logic [SIG_MAX_WIDTH-1:0] poly,
      input int unsigned              width
   );
      logic [SIG_MAX_WIDTH-1:0] mask_v;
      logic [SIG_MAX_WIDTH-1:0] fb_v;
      if (width >= 32'd64) begin
         mask_v = {SIG_MAX_WIDTH{1'b1}};
      end else begin
         mask_v = (64'd1 << width) - 64'd1;
      end
      if (s[6'(width - 32'd1)]) begin
         fb_v = poly;
      end else begin
         fb_v = {SIG_MAX_WIDTH{1'b0}};
      end
      return ((s << 1) ^ fb_v ^ d) & mask_v;
   endfunction

endpackage

// File: rtl/result_sig_monitor_if.sv
// Sample/status bundle of the result signature monitor.
// Optional SIG_MINMAX_EN adds the min_val/max_val outputs.
interface result_sig_monitor_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CW    = 5
);
   logic             start;
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             busy;
   logic             done;
   logic             pass;
   logic [WIDTH-1:0] sig;
   logic [CW-1:0]    count;
`ifdef SIG_MINMAX_EN
   logic [WIDTH-1:0] min_val;
   logic [WIDTH-1:0] max_val;

   modport master (output start, din, din_valid,
                   input  busy, done, pass, sig, count, min_val, max_val);
   modport slave  (input  start, din, din_valid,
                   output busy, done, pass, sig, count, min_val, max_val);
`else
   modport master (output start, din, din_valid,
                   input  busy, done, pass, sig, count);
   modport slave  (input  start, din, din_valid,
                   output busy, done, pass, sig, count);
`endif
endinterface

// File: rtl/sig_misr_reg.sv
// WIDTH-bit MISR register: load reseeds, step absorbs din.
// sig_next exposes the value a step would produce so the owner can compare
// the final signature on the same edge it is captured.
module sig_misr_reg
   import sig_mon_pkg::*;
#(
   parameter int unsigned      WIDTH = 32,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h04C11DB7),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(32'hFFFFFFFF)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] sig,
   output logic [WIDTH-1:0] sig_next
);
   logic [WIDTH-1:0] sig_r;

   assign sig_next = WIDTH'(misr_step(64'(sig_r), 64'(din), 64'(POLY), WIDTH));
   assign sig      = sig_r;

   // Signature register: reseed on reset or load, absorb only on step so an
   // unknown din while idle never reaches the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         sig_r <= SEED;
      end else if (load) begin
         sig_r <= SEED;
      end else if (step) begin
         sig_r <= sig_next;
      end else begin
         sig_r <= sig_r;
      end
   end
endmodule

// File: rtl/result_sig_monitor.sv
// Result signature monitor: compacts NSAMPLES valid samples into a MISR
// signature and flags whether it equals EXP_SIG.
// Optional feature macro: SIG_MINMAX_EN (unsigned min/max of the window).
module result_sig_monitor
   import sig_mon_pkg::*;
#(
   parameter int unsigned      WIDTH    = 32,
   parameter int unsigned      NSAMPLES = 16,
   parameter logic [WIDTH-1:0] POLY     = WIDTH'(32'h04C11DB7),
   parameter logic [WIDTH-1:0] SEED     = WIDTH'(32'hFFFFFFFF),
   parameter logic [WIDTH-1:0] EXP_SIG  = {WIDTH{1'b0}}
) (
   input logic                clk,
   input logic                rst,
   result_sig_monitor_if.slave bus
);
   localparam int unsigned   CW       = $clog2(NSAMPLES + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(NSAMPLES - 1);

   sig_state_e       state_r;
   sig_state_e       state_nxt_s;
   logic             load_s;
   logic             step_s;
   logic             last_s;
   logic [CW-1:0]    count_r;
   logic             busy_r;
   logic             done_r;
   logic             pass_r;
   logic [WIDTH-1:0] sig_s;
   logic [WIDTH-1:0] sig_next_s;

   sig_misr_reg #(
      .WIDTH (WIDTH),
      .POLY  (POLY),
      .SEED  (SEED)
   ) u_misr (
      .clk      (clk),
      .rst      (rst),
      .load     (load_s),
      .step     (step_s),
      .din      (bus.din),
      .sig      (sig_s),
      .sig_next (sig_next_s)
   );

   // Next state and per-cycle controls; start outside RUN reseeds and takes
   // priority over a coincident sample, start inside RUN is ignored.
   always_comb begin
      state_nxt_s = state_r;
      load_s      = 1'b0;
      step_s      = 1'b0;
      last_s      = 1'b0;
      case (state_r)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_nxt_s = S_RUN;
               load_s      = 1'b1;
            end else begin
               state_nxt_s = state_r;
            end
         end
         S_RUN: begin
            if (bus.din_valid) begin
               step_s = 1'b1;
               if (count_r == LAST_CNT) begin
                  last_s      = 1'b1;
                  state_nxt_s = S_DONE;
               end else begin
                  state_nxt_s = S_RUN;
               end
            end else begin
               state_nxt_s = S_RUN;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Counter and status flags; pass is judged on the value the last beat
   // produces so done and pass appear together.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= {CW{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         pass_r  <= 1'b0;
      end else if (load_s) begin
         count_r <= {CW{1'b0}};
         busy_r  <= 1'b1;
         done_r  <= 1'b0;
         pass_r  <= 1'b0;
      end else if (step_s) begin
         count_r <= count_r + CW'(1'b1);
         if (last_s) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            pass_r <= (sig_next_s == EXP_SIG);
         end else begin
            busy_r <= busy_r;
            done_r <= done_r;
            pass_r <= pass_r;
         end
      end else begin
         count_r <= count_r;
         busy_r  <= busy_r;
         done_r  <= done_r;
         pass_r  <= pass_r;
      end
   end

   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.pass  = pass_r;
   assign bus.sig   = sig_s;
   assign bus.count = count_r;

`ifdef SIG_MINMAX_EN
   logic [WIDTH-1:0] min_r;
   logic [WIDTH-1:0] max_r;

   // Unsigned extremes of the absorbed samples; the first sample of a
   // window sets both, later ones only widen the range.
   always_ff @(posedge clk) begin
      if (rst || load_s) begin
         min_r <= {WIDTH{1'b1}};
         max_r <= {WIDTH{1'b0}};
      end else if (step_s) begin
         if (count_r == {CW{1'b0}}) begin
            min_r <= bus.din;
            max_r <= bus.din;
         end else begin
            min_r <= (bus.din < min_r) ? bus.din : min_r;
            max_r <= (bus.din > max_r) ? bus.din : max_r;
         end
      end else begin
         min_r <= min_r;
         max_r <= max_r;
      end
   end

   assign bus.min_val = min_r;
   assign bus.max_val = max_r;
`endif
endmodule

// File: tb/tb_result_sig_monitor.sv
// Bench for result_sig_monitor: directed windows on several configurations,
// final signatures checked by a done-triggered scoreboard.
module tb_result_sig_monitor;
   import sig_mon_pkg::*;

   typedef struct {
      logic [31:0] sig;
      logic        pass;
      int          cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_ab = 1'b0;
   logic        start_c = 1'b0;
   logic        start_d = 1'b0;
   logic        din_valid = 1'b0;
   logic [31:0] din = 32'd0;

   int total = 0;
   int bad   = 0;

   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];
   exp_t qd[$];

   always #5 clk = ~clk;

   // a: small config EXP_SIG=0, b: same with EXP_SIG=3, c: defaults
   result_sig_monitor_if #(.WIDTH(32), .CW(2)) ifa ();
   result_sig_monitor_if #(.WIDTH(32), .CW(2)) ifb ();
   result_sig_monitor_if #(.WIDTH(32), .CW(5)) ifc ();

   assign ifa.start = start_ab; assign ifa.din = din; assign ifa.din_valid = din_valid;
   assign ifb.start = start_ab; assign ifb.din = din; assign ifb.din_valid = din_valid;
   assign ifc.start = start_c;  assign ifc.din = din; assign ifc.din_valid = din_valid;

   result_sig_monitor #(.WIDTH(32), .NSAMPLES(2), .POLY(32'h0), .SEED(32'h0),
                        .EXP_SIG(32'h0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   result_sig_monitor #(.WIDTH(32), .NSAMPLES(2), .POLY(32'h0), .SEED(32'h0),
                        .EXP_SIG(32'h3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
   result_sig_monitor #(.WIDTH(32), .NSAMPLES(16)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

`ifdef SIG_MINMAX_EN
   result_sig_monitor_if #(.WIDTH(32), .CW(2)) ifd ();
   assign ifd.start = start_d; assign ifd.din = din; assign ifd.din_valid = din_valid;
   result_sig_monitor #(.WIDTH(32), .NSAMPLES(3), .POLY(32'h0), .SEED(32'h0),
                        .EXP_SIG(32'h0)) dut_d (.clk(clk), .rst(rst), .bus(ifd));
`endif

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   function automatic exp_t mk(input logic [31:0] s, input logic p, input int c);
      exp_t e;
      e.sig = s; e.pass = p; e.cnt = c;
      return e;
   endfunction

   // Independent bit-level reference of the MISR step.
   function automatic logic [31:0] ref_misr(input logic [31:0] s, input logic [31:0] d,
                                            input logic [31:0] poly);
      logic [31:0] r;
      r[0] = (s[31] & poly[0]) ^ d[0];
      for (int i = 1; i < 32; i++) r[i] = s[i-1] ^ (s[31] & poly[i]) ^ d[i];
      return r;
   endfunction

   function automatic void sb_cmp(input string nm, input exp_t e, input logic [31:0] s,
                                  input logic p, input logic [31:0] c, input logic b);
      chk({nm, "_sig"},   s,       e.sig);
      chk({nm, "_pass"},  32'(p),  32'(e.pass));
      chk({nm, "_count"}, c,       32'(e.cnt));
      chk({nm, "_busy"},  32'(b),  32'd0);
   endfunction

   function automatic void unexpected(input string nm);
      total++;
      bad++;
      $display("FAIL %s: done rose with no expected window queued", nm);
   endfunction

   logic a_done_q = 1'b0, b_done_q = 1'b0, c_done_q = 1'b0, d_done_q = 1'b0;

   // Scoreboard monitor: each done rising edge is compared with the oldest
   // expected window of that instance.
   always @(negedge clk) begin
      if (ifa.done && !a_done_q) begin
         if (qa.size() == 0) unexpected("a_done");
         else sb_cmp("a", qa.pop_front(), ifa.sig, ifa.pass, 32'(ifa.count), ifa.busy);
      end
      if (ifb.done && !b_done_q) begin
         if (qb.size() == 0) unexpected("b_done");
         else sb_cmp("b", qb.pop_front(), ifb.sig, ifb.pass, 32'(ifb.count), ifb.busy);
      end
      if (ifc.done && !c_done_q) begin
         if (qc.size() == 0) unexpected("c_done");
         else sb_cmp("c", qc.pop_front(), ifc.sig, ifc.pass, 32'(ifc.count), ifc.busy);
      end
`ifdef SIG_MINMAX_EN
      if (ifd.done && !d_done_q) begin
         if (qd.size() == 0) unexpected("d_done");
         else sb_cmp("d", qd.pop_front(), ifd.sig, ifd.pass, 32'(ifd.count), ifd.busy);
      end
      d_done_q <= ifd.done;
`endif
      a_done_q <= ifa.done;
      b_done_q <= ifb.done;
      c_done_q <= ifc.done;
   end

   task automatic cyc(input logic sab, input logic sc, input logic sd, input logic v,
                      input logic [31:0] d);
      @(negedge clk);
      start_ab  = sab;
      start_c   = sc;
      start_d   = sd;
      din_valid = v;
      din       = d;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'hxxxxxxxx);
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] stream [16];
      logic [31:0] exp_c;
      logic [63:0] pkg_v;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_a_sig",   ifa.sig,          32'h0);
      chk("rst_a_count", 32'(ifa.count),   32'd0);
      chk("rst_a_flags", 32'({ifa.busy, ifa.done, ifa.pass}), 32'd0);
      chk("rst_c_sig",   ifc.sig,          32'hFFFFFFFF);
      chk("rst_c_flags", 32'({ifc.busy, ifc.done, ifc.pass}), 32'd0);
`ifdef SIG_MINMAX_EN
      chk("rst_d_min",   ifd.min_val,      32'hFFFFFFFF);
      chk("rst_d_max",   ifd.max_val,      32'h0);
`endif
      rst = 1'b0;

      // Test 1: din 1,2 -> sig 1 then 0
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'hxxxxxxxx);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd1);
      chk("t1_busy", 32'(ifa.busy), 32'd1);
      chk("t1_seed", ifa.sig, 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd2);
      chk("t1_sig1", ifa.sig, 32'd1);
      chk("t1_cnt1", 32'(ifa.count), 32'd1);
      qa.push_back(mk(32'd0, 1'b1, 2));
      qb.push_back(mk(32'd0, 1'b0, 2));
      idle();
      chk("t1_done", 32'(ifa.done), 32'd1);

      // Test 2: din 1,1 -> sig 3; pass only where EXP_SIG=3
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'hxxxxxxxx);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd1);
      chk("t2_done_clr", 32'(ifa.done), 32'd0);
      chk("t2_pass_clr", 32'(ifa.pass), 32'd0);
      chk("t2_reseed",   ifa.sig,       32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd1);
      qa.push_back(mk(32'd3, 1'b0, 2));
      qb.push_back(mk(32'd3, 1'b1, 2));
      idle();

      // Test 3: gap of two invalid cycles holds sig and count
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'hxxxxxxxx);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd1);
      idle();
      chk("t3_sig_a",   ifa.sig,        32'd1);
      idle();
      chk("t3_sig_b",   ifa.sig,        32'd1);
      chk("t3_cnt_b",   32'(ifa.count), 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd2);
      chk("t3_sig_c",   ifa.sig,        32'd1);
      chk("t3_notdone", 32'(ifa.done),  32'd0);
      qa.push_back(mk(32'd0, 1'b1, 2));
      qb.push_back(mk(32'd0, 1'b0, 2));
      idle();
      chk("t3_done",    32'(ifa.done),  32'd1);

      // Test 4: reset mid-window, then 5,5 -> 15
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'hxxxxxxxx);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd5);
      idle();
      chk("t4_sig_part", ifa.sig, 32'd5);
      rst = 1'b1;
      idle();
      chk("t4_rst_sig",  ifa.sig,        32'd0);
      chk("t4_rst_cnt",  32'(ifa.count), 32'd0);
      chk("t4_rst_busy", 32'(ifa.busy),  32'd0);
      rst = 1'b0;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'hxxxxxxxx);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd5);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd5);
      qa.push_back(mk(32'd15, 1'b0, 2));
      qb.push_back(mk(32'd15, 1'b0, 2));
      idle();

      // Test 5: upstream {mem}+counter+magic stream on the default config
      exp_c = 32'hFFFFFFFF;
      for (int k = 0; k < 16; k++) begin
         stream[k] = 32'h40302010 + 32'(k) + 32'h000000AB;
         exp_c = ref_misr(exp_c, stream[k], 32'h04C11DB7);
      end
      pkg_v = misr_step(64'hFFFFFFFF, 64'(stream[0]), 64'h04C11DB7, 32);
      chk("pkg_misr_step", 32'(pkg_v), ref_misr(32'hFFFFFFFF, stream[0], 32'h04C11DB7));
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'hxxxxxxxx);
      for (int k = 0; k < 16; k++) begin
         cyc(1'b0, (k < 4) ? 1'b1 : 1'b0, 1'b0, 1'b1, stream[k]);
         if (k == 3) chk("t5_start_ignored", 32'(ifc.count), 32'd3);
      end
      qc.push_back(mk(exp_c, (exp_c == 32'h0), 16));
      idle();
      chk("t5_done", 32'(ifc.done), 32'd1);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, stream[0]);
      idle();
      chk("t5_reseed_sig",  ifc.sig,        32'hFFFFFFFF);
      chk("t5_reseed_cnt",  32'(ifc.count), 32'd0);
      chk("t5_reseed_busy", 32'(ifc.busy),  32'd1);
      chk("t5_reseed_done", 32'(ifc.done),  32'd0);
      for (int k = 0; k < 16; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, stream[k]);
      qc.push_back(mk(exp_c, (exp_c == 32'h0), 16));
      idle();
      chk("t5_done2",       32'(ifc.done),  32'd1);
      chk("t5_a_untouched", ifa.sig,        32'd15);
      chk("t5_a_count",     32'(ifa.count), 32'd2);

`ifdef SIG_MINMAX_EN
      // Test 6: min/max of 7,3,9
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'hxxxxxxxx);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd7);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd3);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd9);
      qd.push_back(mk(32'd19, 1'b0, 3));
      idle();
      chk("t6_min", ifd.min_val, 32'd3);
      chk("t6_max", ifd.max_val, 32'd9);
`endif

      idle();
      idle();
      chk("qa_empty", 32'(qa.size()), 32'd0);
      chk("qb_empty", 32'(qb.size()), 32'd0);
      chk("qc_empty", 32'(qc.size()), 32'd0);
      chk("qd_empty", 32'(qd.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
